// File: rtl/bitmap_index_decoder_if.sv
// Set/clear command ports of the bitmap index decoder.
// Each port is a valid/ready channel carrying one binary index.
interface bitmap_index_decoder_if #(
  parameter int IW = 6
) ();
  logic          set_valid;
  logic          set_ready;
  logic [IW-1:0] set_index;
  logic          clr_valid;
  logic          clr_ready;
  logic [IW-1:0] clr_index;

  modport master (
    output set_valid, set_index,
    output clr_valid, clr_index,
    input  set_ready, clr_ready
  );

  modport slave (
    input  set_valid, set_index,
    input  clr_valid, clr_index,
    output set_ready, clr_ready
  );
endinterface

// File: rtl/bitmap_index_decoder.sv
// Occupancy bitmap driven by set/clear index commands.
// Two-stage pipe: one-hot decode, then read-modify-write of the bitmap.
module bitmap_index_decoder #(
  parameter  int WIDTH      = 64,
  parameter  bit EN_REVERSE = 1'b0,
  localparam int IW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  bitmap_index_decoder_if.slave cmd,
  input  logic             clear_all,
  output logic             clear_all_done,
  output logic [WIDTH-1:0] bitmap_out,
  output logic             bitmap_empty,
  output logic             bitmap_full,
  output logic [IW:0]      set_count,
  output logic             err_set_dup,
  output logic             err_clr_absent,
  output logic             err_range
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLEAR
  } state_t;

  state_t state;

  logic             rdy;
  logic             set_acc;
  logic             clr_acc;
  logic [WIDTH-1:0] s_mask;
  logic [WIDTH-1:0] c_mask;
  logic             s_rng;
  logic             c_rng;
  logic [WIDTH-1:0] kept;
  logic [WIDTH-1:0] nxt;
  logic             inc;
  logic             dec;

  function automatic logic [WIDTH-1:0] onehot(
    input logic [IW-1:0] idx
  );
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(idx) == i) begin
        m[EN_REVERSE ? WIDTH-1-i : i] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic oor(
    input logic [IW-1:0] idx
  );
    return int'(idx) >= WIDTH;
  endfunction

  assign rdy = (state == RUN) & ~clear_all & ~rst;
  assign cmd.set_ready = rdy;
  assign cmd.clr_ready = rdy;
  assign set_acc = cmd.set_valid & rdy;
  assign clr_acc = cmd.clr_valid & rdy;

  // Clear lands before set, so a same-index pair leaves the bit at 1.
  assign kept = bitmap_out & ~c_mask;
  assign nxt  = kept | s_mask;
  assign inc  = |(s_mask & ~kept);
  assign dec  = |(c_mask & bitmap_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      s_mask         <= '0;
      c_mask         <= '0;
      s_rng          <= 1'b0;
      c_rng          <= 1'b0;
      bitmap_out     <= '0;
      set_count      <= '0;
      bitmap_empty   <= 1'b1;
      bitmap_full    <= 1'b0;
      err_set_dup    <= 1'b0;
      err_clr_absent <= 1'b0;
      err_range      <= 1'b0;
      clear_all_done <= 1'b0;
    end else begin
      s_mask <= set_acc ? onehot(cmd.set_index) : '0;
      c_mask <= clr_acc ? onehot(cmd.clr_index) : '0;
      s_rng  <= set_acc & oor(cmd.set_index);
      c_rng  <= clr_acc & oor(cmd.clr_index);

      err_set_dup    <= |(s_mask & bitmap_out & ~c_mask);
      err_clr_absent <= |(c_mask & ~bitmap_out);
      err_range      <= s_rng | c_rng;
      clear_all_done <= 1'b0;

      unique case (state)
        RUN: begin
          if (clear_all) state <= DRAIN;
        end
        DRAIN: begin
          state <= CLEAR;
        end
        CLEAR: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase

      if (state == CLEAR) begin
        bitmap_out     <= '0;
        set_count      <= '0;
        bitmap_empty   <= 1'b1;
        bitmap_full    <= 1'b0;
        clear_all_done <= 1'b1;
      end else begin
        bitmap_out   <= nxt;
        set_count    <= set_count
                      + (IW+1)'(inc)
                      - (IW+1)'(dec);
        bitmap_empty <= (nxt == '0);
        bitmap_full  <= &nxt;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_index_decoder.sv
// Bench for bitmap_index_decoder: directed cases plus random traffic
// on a 64-bit normal and a 48-bit reversed instance.
module tb_bitmap_index_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ca_a = 1'b0;
  logic ca_b = 1'b0;

  always #5 clk = ~clk;

  bitmap_index_decoder_if #(.IW(6)) ifa ();
  bitmap_index_decoder_if #(.IW(6)) ifb ();

  logic        a_done, a_empty, a_full, a_dup, a_abs, a_rng;
  logic [63:0] a_bm;
  logic [6:0]  a_cnt;
  logic        b_done, b_empty, b_full, b_dup, b_abs, b_rng;
  logic [47:0] b_bm;
  logic [6:0]  b_cnt;

  bitmap_index_decoder #(
    .WIDTH(64), .EN_REVERSE(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .cmd(ifa.slave),
    .clear_all(ca_a), .clear_all_done(a_done),
    .bitmap_out(a_bm), .bitmap_empty(a_empty),
    .bitmap_full(a_full), .set_count(a_cnt),
    .err_set_dup(a_dup), .err_clr_absent(a_abs),
    .err_range(a_rng)
  );

  bitmap_index_decoder #(
    .WIDTH(48), .EN_REVERSE(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .cmd(ifb.slave),
    .clear_all(ca_b), .clear_all_done(b_done),
    .bitmap_out(b_bm), .bitmap_empty(b_empty),
    .bitmap_full(b_full), .set_count(b_cnt),
    .err_set_dup(b_dup), .err_clr_absent(b_abs),
    .err_range(b_rng)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          sel;
  int          w;
  bit          rev;
  logic [63:0] m_bm;
  int          m_ph;
  bit          ps_v, pc_v;
  int          ps_i, pc_i;
  bit          m_dup, m_abs, m_rng, m_done;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wmask();
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int pos(input int idx);
    return rev ? (w - 1 - idx) : idx;
  endfunction

  task automatic drive(input bit sv, input int si,
                       input bit cv, input int ci,
                       input bit ca);
    ifa.set_valid = sel ? 1'b0 : sv;
    ifa.set_index = 6'(si);
    ifa.clr_valid = sel ? 1'b0 : cv;
    ifa.clr_index = 6'(ci);
    ifb.set_valid = sel ? sv : 1'b0;
    ifb.set_index = 6'(si);
    ifb.clr_valid = sel ? cv : 1'b0;
    ifb.clr_index = 6'(ci);
    ca_a = sel ? 1'b0 : ca;
    ca_b = sel ? ca : 1'b0;
  endtask

  task automatic check_outs(input string pfx);
    logic [63:0] bm;
    logic [6:0]  cnt;
    bm  = sel ? {16'd0, b_bm} : a_bm;
    cnt = sel ? b_cnt : a_cnt;
    chk({pfx, "_bm"}, bm, m_bm);
    chk({pfx, "_cnt"}, 64'(cnt), 64'($countones(m_bm)));
    chk({pfx, "_empty"}, 64'(sel ? b_empty : a_empty), 64'(m_bm == 0));
    chk({pfx, "_full"}, 64'(sel ? b_full : a_full), 64'(m_bm == wmask()));
    chk({pfx, "_dup"}, 64'(sel ? b_dup : a_dup), 64'(m_dup));
    chk({pfx, "_abs"}, 64'(sel ? b_abs : a_abs), 64'(m_abs));
    chk({pfx, "_rng"}, 64'(sel ? b_rng : a_rng), 64'(m_rng));
    chk({pfx, "_done"}, 64'(sel ? b_done : a_done), 64'(m_done));
  endtask

  task automatic cyc(input bit sv, input int si,
                     input bit cv, input int ci,
                     input bit ca);
    bit          rdy;
    logic [63:0] nb;
    drive(sv, si, cv, ci, ca);
    #1;
    rdy = (m_ph == 0) && !ca;
    chk("set_ready", 64'(sel ? ifb.set_ready : ifa.set_ready), 64'(rdy));
    chk("clr_ready", 64'(sel ? ifb.clr_ready : ifa.clr_ready), 64'(rdy));
    @(posedge clk);
    nb = m_bm;
    m_dup = 0; m_abs = 0; m_rng = 0; m_done = 0;
    if (pc_v) begin
      if (pc_i >= w) m_rng = 1;
      else begin
        if (!m_bm[pos(pc_i)]) m_abs = 1;
        nb[pos(pc_i)] = 1'b0;
      end
    end
    if (ps_v) begin
      if (ps_i >= w) m_rng = 1;
      else begin
        if (nb[pos(ps_i)]) m_dup = 1;
        nb[pos(ps_i)] = 1'b1;
      end
    end
    if (m_ph == 2) begin
      nb = '0;
      m_done = 1;
    end
    m_bm = nb;
    ps_v = sv && rdy; ps_i = si;
    pc_v = cv && rdy; pc_i = ci;
    m_ph = (m_ph == 0) ? (ca ? 1 : 0) : (m_ph == 1 ? 2 : 0);
    #1;
    check_outs("step");
  endtask

  task automatic do_reset(input bit s);
    sel = s;
    w   = s ? 48 : 64;
    rev = s;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_set_ready", 64'(sel ? ifb.set_ready : ifa.set_ready), 64'd0);
    chk("rst_clr_ready", 64'(sel ? ifb.clr_ready : ifa.clr_ready), 64'd0);
    @(posedge clk);
    #1;
    m_bm = '0; m_ph = 0; ps_v = 0; pc_v = 0;
    m_dup = 0; m_abs = 0; m_rng = 0; m_done = 0;
    check_outs("reset");
    rst = 1'b0;
  endtask

  initial begin
    sel = 0; w = 64; rev = 0;
    m_bm = '0; m_ph = 0; ps_v = 0; pc_v = 0; ps_i = 0; pc_i = 0;
    m_dup = 0; m_abs = 0; m_rng = 0; m_done = 0;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // set 5: lands one edge after accept
    do_reset(0);
    cyc(1, 5, 0, 0, 0);
    chk("t1_latency_empty", 64'(a_empty), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("t1_bm", a_bm, 64'h20);
    chk("t1_cnt", 64'(a_cnt), 64'd1);
    chk("t1_empty", 64'(a_empty), 64'd0);

    // duplicate set
    do_reset(0);
    cyc(1, 3, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_dup", 64'(a_dup), 64'd1);
    chk("t2_bm", a_bm, 64'h8);
    chk("t2_cnt", 64'(a_cnt), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("t2_dup_pulse", 64'(a_dup), 64'd0);

    // same-index set+clear on an empty bit
    do_reset(0);
    cyc(1, 7, 1, 7, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t3_bm", a_bm, 64'h80);
    chk("t3_abs", 64'(a_abs), 64'd1);
    chk("t3_cnt", 64'(a_cnt), 64'd1);

    // fill, then clear one
    do_reset(0);
    for (int i = 0; i < 64; i++) cyc(1, i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_full", 64'(a_full), 64'd1);
    chk("t4_cnt", 64'(a_cnt), 64'd64);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_full_drop", 64'(a_full), 64'd0);
    chk("t4_cnt_drop", 64'(a_cnt), 64'd63);

    // clear_all with a set in flight
    do_reset(0);
    for (int i = 0; i < 8; i++) cyc(1, i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 9, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t6_bit9", a_bm, 64'h2FF);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_bm", a_bm, 64'h0);
    chk("t6_done", 64'(a_done), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("t6_done_pulse", 64'(a_done), 64'd0);

    // reversed 48-bit instance
    do_reset(1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_rev", {16'd0, b_bm}, 64'h8000_0000_0000);
    cyc(1, 50, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_rng", 64'(b_rng), 64'd1);
    chk("t5_unch", {16'd0, b_bm}, 64'h8000_0000_0000);

    // random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      do_reset(d[0]);
      for (int n = 0; n < 400; n++) begin
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 63),
            1'($urandom_range(0, 2) == 0), $urandom_range(0, 63),
            1'($urandom_range(0, 49) == 0));
      end
      // reset with an op in flight
      cyc(1, 1, 0, 0, 0);
      do_reset(d[0]);
      cyc(0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitmap_index_decoder.md
Name: bitmap_index_decoder

Overview:
Stateful decoder that maintains a WIDTH-bit occupancy bitmap from encoded index commands. Two independent valid/ready command ports carry binary indices: set (e.g. queue became non-empty) and clear (e.g. queue drained). Each index is decoded to one-hot, and the block keeps the bitmap plus its population count. The bitmap output feeds the scheduler's priority encoder tree; this block produces the vector that the encoder consumes.

Parameters:
WIDTH, 64, bitmap width; any value >= 2, not required to be a power of two
EN_REVERSE, 0, 1 = index i maps to bitmap bit WIDTH-1-i (matches a reversed, LSB-first encoder); 0 = index i maps to bit i
IW, $clog2(WIDTH), index width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
set_valid  input  1  set command valid
set_ready  output  1  set command ready
set_index  input  IW  index to set
clr_valid  input  1  clear command valid
clr_ready  output  1  clear command ready
clr_index  input  IW  index to clear
clear_all  input  1  request to zero the whole bitmap (level, sampled each cycle)
clear_all_done  output  1  one-cycle pulse when the bitmap has been zeroed
bitmap_out  output  WIDTH  registered occupancy bitmap
bitmap_empty  output  1  bitmap_out == 0
bitmap_full  output  1  all WIDTH bits set
set_count  output  IW+1  number of set bits, 0..WIDTH
err_set_dup  output  1  pulse: set hit a bit that was already 1
err_clr_absent  output  1  pulse: clear hit a bit that was already 0
err_range  output  1  pulse: accepted index >= WIDTH (either port)

Behaviour:
- Reset (async):
  - bitmap_out=0, set_count=0, bitmap_empty=1, bitmap_full=0.
  - All error pulses and clear_all_done are 0.
  - FSM goes to RUN; stage-1 valids are cleared.
  - set_ready and clr_ready are 0 while rst is high.
- Handshake:
  - A command is accepted on a rising edge where valid & ready.
  - set_ready = clr_ready = (state==RUN) & ~clear_all. The ready signals do not depend on valid.
  - Both ports can be accepted in the same cycle.
- Pipeline stage 1, on the accept edge:
  - Register the one-hot masks S and C, with EN_REVERSE mapping applied.
  - Register a range flag per port.
  - An out-of-range index gives an all-zero mask.
- Pipeline stage 2, on the next edge:
  - bitmap <= (bitmap & ~C) | S. Clear is applied before set, so a same-index set+clear leaves the bit at 1.
  - set_count <= set_count + (S hits a bit of (bitmap & ~C) that is 0) - (C hits a bit of bitmap that is 1).
  - bitmap_empty and bitmap_full are registered alongside the bitmap and are consistent with it.
- Latency: a command accepted at edge N is visible on bitmap_out and set_count after edge N+1.
- Back-to-back commands to the same index are legal and carry no hazard, because stage 2 always reads the current register.
- Error pulses are high for exactly one cycle, aligned with the stage-2 update.
  - err_set_dup: S & bitmap & ~C is nonzero.
  - err_clr_absent: C & ~bitmap is nonzero.
  - err_range: either stage-1 range flag is set. The bitmap is unchanged for that port.
- FSM (RUN, DRAIN, CLEAR):
  - RUN -> DRAIN when clear_all=1. Ready is already low in that cycle.
  - DRAIN: no new accepts; any stage-1 op completes in stage 2. Always -> CLEAR after one cycle.
  - CLEAR: bitmap<=0, set_count<=0, empty<=1, full<=0, clear_all_done pulses. -> RUN.
  - In RUN with clear_all still high, the sequence repeats. clear_all is expected to be a pulse.
- Reset mid-operation: any in-flight stage-1 op is discarded and the FSM returns to RUN.
- Boundaries:
  - Non-power-of-two WIDTH: indices WIDTH..2^IW-1 are out of range.
  - set_count never wraps; by construction it stays within 0..WIDTH.

Test Plan:
- Reset then set_index=5 at edge N (WIDTH=64) -> bitmap_out=0x20 and set_count=1 after edge N+1; bitmap_empty 1->0 on that edge.
- Set 3, then set 3 again -> second op pulses err_set_dup; bitmap stays 0x8, set_count stays 1.
- Same-cycle set_index=7 and clr_index=7 with bit 7 at 0 -> bit 7 becomes 1, err_clr_absent pulses, set_count +1.
- Set all 64 indices, one per cycle -> bitmap_full=1 and set_count=64. Then clr_index=0 -> full=0, count=63.
- WIDTH=48, EN_REVERSE=1: set_index=0 -> bitmap bit 47 set. set_index=50 -> err_range pulse, bitmap unchanged.
- Bitmap 0xFF, clear_all pulse with set_index=9 accepted the cycle before -> ready low for 3 cycles. Bit 9 lands, then bitmap=0, count=0, clear_all_done pulses once, ready returns.
